// File: rtl/pe_array_input_arb.sv
// rtl/pe_array_input_arb.sv - round-robin burst arbiter feeding the PE-array input port
//
// Purpose:
//   Shares the single PE-array input port among NUM_REQ feeders. One requester is
//   granted for BURST_LEN beats, then the arbiter returns to IDLE for one cycle and
//   re-arbitrates starting at the requester after the one just served. Beats leave
//   through a registered valid/ready output stage.
//
// Optional feature (macro PE_ARB_TIMEOUT_EN):
//   Adds a stall counter that aborts a burst after TIMEOUT consecutive cycles with
//   the granted requester idle, pulsing err_timeout for one cycle. Without the
//   macro err_timeout is tied 0 and a grant is held indefinitely.
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]         per-requester beat valid
//   req_ready    out  [NUM_REQ]         per-requester beat accept (combinational)
//   req_data     in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   ovalid       out                    beat valid to PE array
//   oready       in                     PE array accept
//   odata        out  [DATA_W]          beat to PE array
//   ogrant_id    out  [IDW]             source of the beat on odata
//   busy         out                    BURST state or output register occupied
//   err_timeout  out                    single-cycle burst abort pulse

module pe_array_input_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      ovalid,
    input  logic                      oready,
    output logic [DATA_W-1:0]         odata,
    output logic [IDW-1:0]            ogrant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      r_grant;
    logic [CW-1:0]       r_beat_cnt;
    logic                r_ovalid;
    logic [DATA_W-1:0]   r_odata;
    logic [IDW-1:0]      r_ogrant_id;

    logic                w_any;
    logic [IDW-1:0]      w_pick;
    logic [IDW-1:0]      w_grant_inc;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_ready;
    logic                w_xfer;
    logic                w_last;
    logic                w_abort;

    // Round-robin pick: scan offsets from the highest down so that the smallest
    // offset from r_rr_ptr with a valid request is the one left in w_pick.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_any  = 1'b1;
                w_pick = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_grant_inc = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_sel_valid = req_valid[r_grant];
    assign w_sel_data  = req_data[int'(r_grant) * DATA_W +: DATA_W];

    // The granted requester may push whenever the output register is empty or
    // draining this cycle, which gives one beat per cycle under oready=1.
    assign w_ready = (r_state == S_BURST) && (!r_ovalid || oready);
    assign w_xfer  = w_ready && w_sel_valid;
    assign w_last  = w_xfer && (r_beat_cnt == CW'(BURST_LEN - 1));

    always_comb begin
        req_ready = '0;
        if (w_ready) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_last || w_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_beat_cnt  <= '0;
            r_ovalid    <= 1'b0;
            r_odata     <= '0;
            r_ogrant_id <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
            end

            if (w_xfer) begin
                r_beat_cnt  <= r_beat_cnt + 1'b1;
                r_odata     <= w_sel_data;
                r_ogrant_id <= r_grant;
                r_ovalid    <= 1'b1;
            end else if (oready) begin
                r_ovalid    <= 1'b0;
            end

            if (w_last || w_abort) begin
                r_rr_ptr <= w_grant_inc;
            end
        end
    end

`ifdef PE_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] r_stall_cnt;
    logic          r_err_timeout;

    // Abort on the cycle that would bring the stall count to TIMEOUT. A beat
    // already in the output register is untouched and drains normally.
    assign w_abort = (r_state == S_BURST) && !w_sel_valid &&
                     (r_stall_cnt == SW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt   <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_abort;
            if ((r_state != S_BURST) || w_xfer || w_abort) begin
                r_stall_cnt <= '0;
            end else if (!w_sel_valid) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_abort     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign ovalid    = r_ovalid;
    assign odata     = r_odata;
    assign ogrant_id = r_ogrant_id;
    assign busy      = (r_state == S_BURST) || r_ovalid;

endmodule

// File: doc/pe_array_input_arb.md
Name: pe_array_input_arb

Overview:
- Round-robin burst arbiter that shares the single PE-array input port among NUM_REQ feeders (weight loader, activation streamer, test-pattern source, etc.).
- Grants one requester for a fixed burst of BURST_LEN beats, then re-arbitrates.
- Drives the PE array through a registered valid/ready output stage.
- Sits between the feeder ports and the PE-array input interface (ivalid/idata).

Parameters:
- NUM_REQ, 4, number of requesters; range 2..16.
- DATA_W, 256, width of one PE-array input beat.
- BURST_LEN, 8, beats per grant; range 1..255.
- TIMEOUT, 64, stall-cycle limit; used only with the optional feature; range 1..1023.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- ovalid  out  1  beat valid to PE array.
- oready  in  1  PE array accept.
- odata  out  DATA_W  beat to PE array.
- ogrant_id  out  max(1,clog2(NUM_REQ))  source of the beat currently on odata.
- busy  out  1  high while in BURST state or ovalid is high.
- err_timeout  out  1  single-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset: all of the following are asserted asynchronously on resetn low and held until resetn rises:
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0
  - ovalid=0, odata=0, ogrant_id=0, req_ready=0, busy=0, err_timeout=0
- Reset mid-burst discards the in-flight beat and the remaining burst; nothing is replayed.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, grant = first index at or cyclically after rr_ptr with req_valid=1.
  - Go to BURST and clear beat_cnt.
  - Otherwise stay in IDLE.
  - req_ready is 0 in IDLE.
- BURST:
  - req_ready[grant] = !ovalid || oready. All other req_ready bits are 0. req_ready is combinational from state and the output register.
  - A beat transfers when req_valid[grant] && req_ready[grant].
  - On transfer: odata <= req_data[grant], ogrant_id <= grant, ovalid <= 1, beat_cnt++.
  - When the transfer makes beat_cnt reach BURST_LEN: go to IDLE, rr_ptr <= (grant+1) mod NUM_REQ.
- Output stage:
  - If ovalid && oready and no new beat is loaded that cycle, ovalid <= 0.
  - odata and ogrant_id hold while ovalid && !oready.
  - Full throughput inside a burst: one beat per cycle while oready=1.
- Latency:
  - req_valid rising in IDLE at cycle t: grant decided at edge t+1, req_ready high in cycle t+1, first beat on odata/ovalid in cycle t+2.
  - Exactly one IDLE bubble cycle between consecutive bursts.
- The requester may deassert req_valid mid-burst. The grant is held, beat_cnt pauses, and no other requester is served.
- Simultaneous requests: resolved strictly by rr_ptr order. A requester that is not yet requesting when arbitration occurs waits for the next IDLE.
- BURST_LEN=1: every beat re-arbitrates; steady state is 1 beat per 2 cycles.
- rr_ptr wraps from NUM_REQ-1 to 0. beat_cnt width is clog2(BURST_LEN+1).
- busy = (state==BURST) || ovalid.

Optional Feature:
- Macro: PE_ARB_TIMEOUT_EN.
- When defined, a stall counter runs in BURST:
  - Increments each cycle req_valid[grant]=0.
  - Clears on any transfer and on entering BURST.
  - On reaching TIMEOUT: abort the burst, go to IDLE, set rr_ptr <= grant+1, pulse err_timeout for 1 cycle.
  - A beat already in the output register still drains normally.
- When undefined: no counter is built, err_timeout is constant 0, and the grant holds indefinitely.

Test Plan:
- Single requester: req_valid[2]=1 continuously, oready=1, BURST_LEN=8. Expect 8 beats in cycles t+2..t+9 with ogrant_id=2, one bubble cycle, then the next burst.
- All four requesting from reset, rr_ptr=0. Expect burst order 0,1,2,3,0 with 8 beats each; odata matches each source's counting pattern, with no loss or duplication.
- Backpressure: oready low for 5 cycles mid-burst. Expect ovalid to stay 1, odata/ogrant_id stable, req_ready[grant]=0 during the stall, and exactly 8 beats total after release.
- Requester gap: requester 1 drops valid for 10 cycles after beat 3 while requester 0 is requesting. Expect no beats from 0 until 1 completes beat 8 (feature off).
- PE_ARB_TIMEOUT_EN with TIMEOUT=4: same gap. Expect an err_timeout pulse 4 cycles after the last transfer, and requester 2 or 0 granted next per rr_ptr=2.
- resetn pulsed low for 1 cycle mid-burst while ovalid=1. Expect ovalid, req_ready and busy to go 0 immediately (asynchronously), and arbitration to restart at requester 0.
